// File: rtl/vector_lsu_if.sv
// rtl/vector_lsu_if.sv - single-word memory request/response port of the vector load/store unit
interface vector_lsu_if #(
    parameter int ADDR_W = 36,
    parameter int DATA_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/vector_lsu.sv
// rtl/vector_lsu.sv - strided, lane-masked 4-lane vector load/store unit, one memory request in flight
module vector_lsu #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        stride,
    input  logic [LANES-1:0]  lane_mask,
    input  logic [DATA_W-1:0] vdata_in  [LANES-1:0],
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] vdata_out [LANES-1:0],
    vector_lsu_if.master      mem
);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              store_q;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        stride_q;
    logic [LANES-1:0]  mask_q;
    logic [DATA_W-1:0] wdata_q  [LANES-1:0];
    logic [DATA_W-1:0] result_q [LANES-1:0];
    logic [LANE_W-1:0] lane_q;
    logic [LANE_W-1:0] first_lane;
    logic [LANE_W-1:0] next_lane;
    logic              has_next;
    logic [ADDR_W-1:0] stride_ext;
    logic [ADDR_W-1:0] lane_addr;
    logic              accept;
    logic              req_fire;
    logic              resp_fire;
    logic              advance;

    assign accept    = (state == IDLE) && start;
    assign req_fire  = (state == REQ) && mem.mem_req_ready;
    assign resp_fire = (state == WAIT_RESP) && mem.mem_resp_valid;
    assign advance   = (req_fire && store_q) || resp_fire;

    // Lowest enabled lane of the incoming mask; scanning downward lets the last hit win.
    always_comb begin
        first_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_mask[i]) first_lane = LANE_W'(i);
        end
    end

    always_comb begin
        has_next  = 1'b0;
        next_lane = lane_q;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i] && (LANE_W'(i) > lane_q)) begin
                has_next  = 1'b1;
                next_lane = LANE_W'(i);
            end
        end
    end

    // Truncation to ADDR_W gives the required modulo-2^ADDR_W wrap for free.
    assign stride_ext = {{(ADDR_W - 8){stride_q[7]}}, stride_q};
    assign lane_addr  = base_q + stride_ext * ADDR_W'(lane_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (lane_mask == '0) ? DONE : REQ;
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    if (!store_q)      state_nxt = WAIT_RESP;
                    else if (has_next) state_nxt = REQ;
                    else               state_nxt = DONE;
                end
            end
            WAIT_RESP: begin
                if (mem.mem_resp_valid) state_nxt = has_next ? REQ : DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy              = (state != IDLE);
        done              = (state == DONE);
        mem.mem_req_valid = 1'b0;
        mem.mem_req_we    = 1'b0;
        mem.mem_req_addr  = '0;
        mem.mem_req_wdata = '0;
        if (state == REQ) begin
            mem.mem_req_valid = 1'b1;
            mem.mem_req_we    = store_q;
            mem.mem_req_addr  = lane_addr;
            mem.mem_req_wdata = store_q ? wdata_q[lane_q] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q  <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            mask_q   <= '0;
            lane_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                wdata_q[i]  <= '0;
                result_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                store_q  <= is_store;
                base_q   <= base_addr;
                stride_q <= stride;
                mask_q   <= lane_mask;
                lane_q   <= first_lane;
                for (int i = 0; i < LANES; i++) begin
                    wdata_q[i] <= vdata_in[i];
                    if (!is_store) result_q[i] <= '0;
                end
            end
            if (resp_fire) result_q[lane_q] <= mem.mem_resp_data;
            if (advance)   lane_q <= next_lane;
        end
    end

    assign vdata_out = result_q;
endmodule

// File: tb/tb_vector_lsu.sv
// tb/tb_vector_lsu.sv - randomized self-checking bench for vector_lsu against a lane-list reference model
module tb_vector_lsu;
    localparam int ADDR_W = 36;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              is_store;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        stride;
    logic [3:0]        lane_mask;
    logic [DATA_W-1:0] vdata_in  [3:0];
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] vdata_out [3:0];

    vector_lsu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

    vector_lsu #(.LANES(4), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .base_addr(base_addr),
        .stride(stride), .lane_mask(lane_mask), .vdata_in(vdata_in), .busy(busy), .done(done),
        .vdata_out(vdata_out), .mem(mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [35:0] obs_addr[$];
    logic        obs_we[$];
    logic [31:0] obs_wdata[$];
    int          obs_rel[$];
    int          obs_unstable, obs_extra, obs_valid_cycles, obs_done_rel;
    bit          obs_timeout;
    logic        obs_busy_after;
    logic [31:0] rsp_q[$];
    logic [31:0] model_v [3:0];

    function automatic logic [35:0] lane_addr(input logic [35:0] b, input logic [7:0] s, input int i);
        longint sx;
        sx = longint'($signed(s));
        return 36'(longint'(b) + sx * longint'(i));
    endfunction

    // Memory-side driver: accepts requests after random stalls and returns load data from rsp_q.
    task automatic exec_op(input bit st, input logic [35:0] b, input logic [7:0] s, input logic [3:0] m,
                           input logic [127:0] d, input int smin, input int smax, input int gap, input bit noise);
        int t0, rel, stall, rcnt;
        bit pend, rwait;
        logic [35:0] la;
        logic lw;
        logic [31:0] ld;
        obs_addr.delete(); obs_we.delete(); obs_wdata.delete(); obs_rel.delete();
        obs_unstable = 0; obs_extra = 0; obs_valid_cycles = 0; obs_done_rel = -1; obs_timeout = 1;
        pend = 0; rwait = 0; stall = 0; rcnt = 0; la = '0; lw = 0; ld = '0;
        is_store = st; base_addr = b; stride = s; lane_mask = m;
        for (int i = 0; i < 4; i++) vdata_in[i] = d[32*i +: 32];
        start = 1;
        @(posedge clk); #1;
        t0 = cyc;
        for (int n = 0; n < 200; n++) begin
            rel = cyc - t0 + 1;
            start = 0; mem.mem_req_ready = 0; mem.mem_resp_valid = 0; mem.mem_resp_data = '0;
            if (done) begin obs_done_rel = rel; obs_timeout = 0; break; end
            if (mem.mem_req_valid) obs_valid_cycles++;
            if (rwait) begin
                if (rcnt == 0) begin
                    mem.mem_resp_valid = 1;
                    mem.mem_resp_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
                    rwait = 0;
                end else begin
                    rcnt--; obs_extra++;
                end
            end else if (mem.mem_req_valid) begin
                if (!pend) begin
                    pend = 1; la = mem.mem_req_addr; lw = mem.mem_req_we; ld = mem.mem_req_wdata;
                    obs_addr.push_back(la); obs_we.push_back(lw); obs_wdata.push_back(ld); obs_rel.push_back(rel);
                    stall = $urandom_range(smax, smin);
                end else if (mem.mem_req_addr !== la || mem.mem_req_we !== lw || mem.mem_req_wdata !== ld) begin
                    obs_unstable++;
                end
                if (stall == 0) begin
                    mem.mem_req_ready = 1; pend = 0;
                    if (!lw) begin rwait = 1; rcnt = gap; end
                end else begin
                    stall--; obs_extra++;
                    if (noise) begin mem.mem_resp_valid = 1; mem.mem_resp_data = $urandom; end
                end
            end
            if (noise && busy) begin
                start = 1; is_store = 1'($urandom); base_addr = {4'($urandom), $urandom}; lane_mask = 4'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 0; mem.mem_req_ready = 0; mem.mem_resp_valid = 0;
        @(posedge clk); #1;
        obs_busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; is_store = 0; base_addr = '0; stride = '0; lane_mask = '0;
        for (int i = 0; i < 4; i++) begin vdata_in[i] = '0; model_v[i] = '0; end
        mem.mem_req_ready = 0; mem.mem_resp_valid = 0; mem.mem_resp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if ({mem.mem_req_valid, mem.mem_req_we} !== 2'b00) begin errors++; $display("FAIL reset_req_ctl: got %b want 00", {mem.mem_req_valid, mem.mem_req_we}); end
        checks++; if (mem.mem_req_addr !== '0 || mem.mem_req_wdata !== '0) begin errors++; $display("FAIL reset_req_bus: addr %h wdata %h want 0", mem.mem_req_addr, mem.mem_req_wdata); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vdata_out[i] !== '0) begin errors++; $display("FAIL reset_vdata[%0d]: got %h want 0", i, vdata_out[i]); end
        end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_store();
        logic [31:0] exp_w [4] = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
        exec_op(1, 36'h100, 8'd1, 4'b1111, {32'hD3, 32'hC2, 32'hB1, 32'hA0}, 0, 0, 0, 0);
        checks++; if (obs_timeout) begin errors++; $display("FAIL store_timeout: no done within bound"); end
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL store_count: got %0d want 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== 36'h100 + 36'(i) || obs_we[i] !== 1'b1 || obs_wdata[i] !== exp_w[i] || obs_rel[i] != i + 1) begin
                errors++;
                $display("FAIL store_req[%0d]: got addr %h we %b data %h cyc %0d want addr %h we 1 data %h cyc %0d",
                         i, obs_addr[i], obs_we[i], obs_wdata[i], obs_rel[i], 36'h100 + 36'(i), exp_w[i], i + 1);
            end
        end
        checks++; if (obs_done_rel != 5) begin errors++; $display("FAIL store_done_cycle: got T+%0d want T+5", obs_done_rel); end
        checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL store_busy_after: got %b want 0", obs_busy_after); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vdata_out[i] !== model_v[i]) begin errors++; $display("FAIL store_keeps_vdata[%0d]: got %h want %h", i, vdata_out[i], model_v[i]); end
        end
    endtask

    task automatic test_load_masked();
        logic [35:0] exp_a [3] = '{36'h20, 36'h1E, 36'h1A};
        rsp_q = '{32'd11, 32'd22, 32'd33};
        exec_op(0, 36'h20, 8'hFE, 4'b1011, '0, 0, 0, 0, 0);
        model_v[0] = 32'd11; model_v[1] = 32'd22; model_v[2] = 32'd0; model_v[3] = 32'd33;
        checks++; if (obs_addr.size() != 3) begin errors++; $display("FAIL load_count: got %0d want 3", obs_addr.size()); end
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_a[i] || obs_we[i] !== 1'b0 || obs_wdata[i] !== '0) begin
                errors++; $display("FAIL load_req[%0d]: got addr %h we %b data %h want addr %h we 0 data 0", i, obs_addr[i], obs_we[i], obs_wdata[i], exp_a[i]);
            end
        end
        checks++; if (obs_done_rel != 7) begin errors++; $display("FAIL load_done_cycle: got T+%0d want T+7", obs_done_rel); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vdata_out[i] !== model_v[i]) begin errors++; $display("FAIL load_vdata[%0d]: got %h want %h", i, vdata_out[i], model_v[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] b;
        b = {4'($urandom), $urandom};
        exec_op(1, b, 8'($urandom), 4'b0001, {96'h0, 32'h5A5A1234}, 3, 3, 0, 0);
        checks++; if (obs_addr.size() != 1 || obs_addr[0] !== b || obs_wdata[0] !== 32'h5A5A1234) begin
            errors++; $display("FAIL bp_req: got %0d reqs first addr %h data %h want 1 req addr %h data 5a5a1234",
                               obs_addr.size(), obs_addr.size() ? obs_addr[0] : 36'h0, obs_wdata.size() ? obs_wdata[0] : 32'h0, b);
        end
        checks++; if (obs_unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", obs_unstable); end
        checks++; if (obs_valid_cycles != 4) begin errors++; $display("FAIL bp_valid_cycles: got %0d want 4", obs_valid_cycles); end
        checks++; if (obs_done_rel != 5) begin errors++; $display("FAIL bp_done_cycle: got T+%0d want T+5", obs_done_rel); end
    endtask

    task automatic test_empty_and_wrap();
        exec_op(0, 36'h123, 8'd4, 4'b0000, '0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) model_v[i] = '0;
        checks++; if (obs_done_rel != 1) begin errors++; $display("FAIL empty_done_cycle: got T+%0d want T+1", obs_done_rel); end
        checks++; if (obs_valid_cycles != 0) begin errors++; $display("FAIL empty_traffic: got %0d valid cycles want 0", obs_valid_cycles); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vdata_out[i] !== '0) begin errors++; $display("FAIL empty_vdata[%0d]: got %h want 0", i, vdata_out[i]); end
        end
        exec_op(1, 36'hFFFFFFFFF, 8'd1, 4'b0011, {64'h0, 32'h2, 32'h1}, 0, 1, 0, 0);
        checks++; if (obs_addr.size() != 2 || obs_addr[0] !== 36'hFFFFFFFFF || obs_addr[1] !== 36'h0) begin
            errors++; $display("FAIL wrap_addr: got %0d reqs %h %h want fffffffff 000000000", obs_addr.size(),
                               obs_addr.size() > 0 ? obs_addr[0] : 36'h0, obs_addr.size() > 1 ? obs_addr[1] : 36'h0);
        end
    endtask

    task automatic test_reset_mid_load();
        is_store = 0; base_addr = 36'h40; stride = 8'd1; lane_mask = 4'b0001; start = 1;
        @(posedge clk); #1;
        start = 0;
        checks++; if (mem.mem_req_valid !== 1'b1) begin errors++; $display("FAIL rml_req: got valid %b want 1", mem.mem_req_valid); end
        mem.mem_req_ready = 1;
        @(posedge clk); #1;
        mem.mem_req_ready = 0;
        checks++; if ({busy, mem.mem_req_valid} !== 2'b10) begin errors++; $display("FAIL rml_wait: got busy/valid %b want 10", {busy, mem.mem_req_valid}); end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++; if ({busy, done, mem.mem_req_valid, mem.mem_req_we} !== 4'b0000 || mem.mem_req_addr !== '0 || mem.mem_req_wdata !== '0) begin
            errors++; $display("FAIL rml_outputs: got busy %b done %b valid %b we %b addr %h wdata %h want all 0",
                               busy, done, mem.mem_req_valid, mem.mem_req_we, mem.mem_req_addr, mem.mem_req_wdata);
        end
        mem.mem_resp_valid = 1; mem.mem_resp_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem.mem_resp_valid = 0;
        for (int i = 0; i < 4; i++) model_v[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({busy, done, mem.mem_req_valid} !== 3'b000) begin errors++; $display("FAIL rml_stray_state: got busy/done/valid %b want 000", {busy, done, mem.mem_req_valid}); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vdata_out[i] !== '0) begin errors++; $display("FAIL rml_stray_vdata[%0d]: got %h want 0", i, vdata_out[i]); end
        end
    endtask

    task automatic test_illegal_events();
        logic [31:0] r [4];
        for (int i = 0; i < 4; i++) begin r[i] = $urandom; rsp_q.push_back(r[i]); model_v[i] = r[i]; end
        exec_op(0, 36'h800, 8'd3, 4'b1111, '0, 1, 2, 1, 1);
        checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL illegal_count: got %0d want 4", obs_addr.size()); end
        for (int i = 0; i < 4 && i < obs_addr.size(); i++) begin
            checks++; if (obs_addr[i] !== lane_addr(36'h800, 8'd3, i) || obs_we[i] !== 1'b0) begin
                errors++; $display("FAIL illegal_req[%0d]: got addr %h we %b want addr %h we 0", i, obs_addr[i], obs_we[i], lane_addr(36'h800, 8'd3, i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vdata_out[i] !== model_v[i]) begin errors++; $display("FAIL illegal_vdata[%0d]: got %h want %h", i, vdata_out[i], model_v[i]); end
        end
        checks++; if (obs_done_rel != 9 + obs_extra) begin errors++; $display("FAIL illegal_done_cycle: got T+%0d want T+%0d", obs_done_rel, 9 + obs_extra); end
        checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL illegal_restart: busy %b after done want 0", obs_busy_after); end
    endtask

    task automatic test_random();
        bit          st, noise;
        logic [35:0] b;
        logic [7:0]  s;
        logic [3:0]  m;
        logic [127:0] d;
        logic [31:0] r [4];
        int          gap, cnt, j;
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom); noise = 1'($urandom); s = 8'($urandom); m = 4'($urandom);
            b = (n % 4 == 0) ? 36'hFFFFFFFFF - 36'($urandom_range(3, 0)) : {4'($urandom), $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            gap = $urandom_range(2, 0);
            rsp_q.delete();
            for (int i = 0; i < 4; i++) begin r[i] = $urandom; rsp_q.push_back(r[i]); end
            exec_op(st, b, s, m, d, 0, 2, gap, noise);
            cnt = $countones(m);
            if (!st) for (int i = 0; i < 4; i++) model_v[i] = '0;
            checks++; if (obs_timeout) begin errors++; $display("FAIL rand_timeout: op %0d no done within bound", n); end
            checks++; if (obs_addr.size() != cnt) begin errors++; $display("FAIL rand_count: op %0d got %0d want %0d", n, obs_addr.size(), cnt); end
            j = 0;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    if (j < obs_addr.size()) begin
                        checks++;
                        if (obs_addr[j] !== lane_addr(b, s, i) || obs_we[j] !== st || obs_wdata[j] !== (st ? d[32*i +: 32] : 32'h0)) begin
                            errors++; $display("FAIL rand_req: op %0d lane %0d got addr %h we %b data %h want addr %h we %b data %h", n, i,
                                               obs_addr[j], obs_we[j], obs_wdata[j], lane_addr(b, s, i), st, st ? d[32*i +: 32] : 32'h0);
                        end
                    end
                    if (!st) model_v[i] = r[j];
                    j++;
                end
            end
            checks++; if (obs_unstable != 0) begin errors++; $display("FAIL rand_stable: op %0d got %0d unstable cycles want 0", n, obs_unstable); end
            checks++; if (obs_done_rel != 1 + cnt * (st ? 1 : 2) + obs_extra) begin
                errors++; $display("FAIL rand_done_cycle: op %0d got T+%0d want T+%0d", n, obs_done_rel, 1 + cnt * (st ? 1 : 2) + obs_extra);
            end
            checks++; if (obs_busy_after !== 1'b0) begin errors++; $display("FAIL rand_busy_after: op %0d got %b want 0", n, obs_busy_after); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (vdata_out[i] !== model_v[i]) begin errors++; $display("FAIL rand_vdata: op %0d lane %0d got %h want %h", n, i, vdata_out[i], model_v[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, r1;
        r0 = $urandom; r1 = $urandom;
        rsp_q = '{r0, r1};
        exec_op(0, 36'h200, 8'h80, 4'b1001, '0, 0, 0, 0, 0);
        model_v[0] = r0; model_v[1] = '0; model_v[2] = '0; model_v[3] = r1;
        checks++; if (obs_done_rel != 5) begin errors++; $display("FAIL b2b_load_done: got T+%0d want T+5", obs_done_rel); end
        checks++; if (obs_addr.size() != 2 || obs_addr[1] !== lane_addr(36'h200, 8'h80, 3)) begin
            errors++; $display("FAIL b2b_load_addr: got %0d reqs want 2 with lane3 addr %h", obs_addr.size(), lane_addr(36'h200, 8'h80, 3));
        end
        exec_op(1, 36'h300, 8'd2, 4'b0110, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0);
        checks++; if (obs_done_rel != 3) begin errors++; $display("FAIL b2b_store_done: got T+%0d want T+3", obs_done_rel); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (vdata_out[i] !== model_v[i]) begin errors++; $display("FAIL b2b_vdata[%0d]: got %h want %h", i, vdata_out[i], model_v[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_store();
        test_load_masked();
        test_backpressure();
        test_empty_and_wrap();
        test_illegal_events();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store unit that sits behind the vector execute stage and moves one 4-lane × 32-bit vector to or from the data memory port. A store serializes the vector into up to four single-word write requests. A load issues up to four single-word read requests and gathers the in-order responses back into a 4-lane vector. Transfers are strided and lane-masked, with one request outstanding at a time. The pipeline holds on `busy` until `done` pulses.

## Interface
Parameters:
- `LANES`, 4, number of vector lanes; fixed at 4 in this design.
- `DATA_W`, 32, lane and memory word width.
- `ADDR_W`, 36, word address width.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `start`, input, 1, operation request; sampled only in IDLE.
- `is_store`, input, 1, 1 = store, 0 = load; latched at accept.
- `base_addr`, input, `ADDR_W`, word address of lane 0; latched at accept.
- `stride`, input, 8, signed word stride; latched at accept.
- `lane_mask`, input, 4, bit i = 1 enables lane i; latched at accept.
- `vdata_in`, input, `DATA_W` × 4 (unpacked `[3:0]`), store data; latched at accept.
- `busy`, output, 1, high while an operation is in progress.
- `done`, output, 1, one-cycle completion pulse.
- `vdata_out`, output, `DATA_W` × 4 (unpacked `[3:0]`), load result; held until the next load is accepted.
- `mem_req_valid`, output, 1, memory request valid.
- `mem_req_ready`, input, 1, memory accepts the request this cycle.
- `mem_req_we`, output, 1, 1 = write.
- `mem_req_addr`, output, `ADDR_W`, request word address.
- `mem_req_wdata`, output, `DATA_W`, write data.
- `mem_resp_valid`, input, 1, read data valid; responses arrive in order.
- `mem_resp_data`, input, `DATA_W`, read data.

## Operation
- States: IDLE, REQ, WAIT_RESP, DONE.
- **Accept:** in IDLE with `start` = 1, latch all operation inputs and set lane pointer to the lowest enabled lane.
  - Load: clear the result register to 0 at accept.
  - `lane_mask` = 0: go directly to DONE.
  - Otherwise: go to REQ.
- **Lane address:** addr_i = `base_addr` + sign_extend(`stride`) × i, truncated to `ADDR_W` bits (wraps modulo 2^`ADDR_W`).
- **REQ:**
  - Drive `mem_req_valid` = 1, `mem_req_we` = is_store, and the current lane's address.
  - `mem_req_wdata` = latched lane data for stores, 0 for loads.
  - Address, data and `we` stay stable until `mem_req_ready` is seen.
  - On `mem_req_ready`, a store advances to the next enabled lane, or to DONE if none remain.
  - On `mem_req_ready`, a load goes to WAIT_RESP.
- **WAIT_RESP:**
  - `mem_req_valid` = 0.
  - On `mem_resp_valid`, write `mem_resp_data` into the current lane of the result register.
  - Then advance to the next enabled lane (back to REQ), or to DONE if none remain.
- **DONE:** `done` = 1 for exactly one cycle, `vdata_out` is valid, next state is IDLE.
- **Masked lanes:** for loads, masked lanes read as 0; no request is issued for any masked lane.
- **Ignored inputs:**
  - `start` outside IDLE.
  - `mem_resp_valid` in IDLE, REQ or DONE (no response is legal on the same cycle its request is accepted).
- **`busy`:** 1 in REQ, WAIT_RESP and DONE; 0 in IDLE.

## Timing
- Reset values: state IDLE, `busy` = 0, `done` = 0, `mem_req_valid` = 0, `mem_req_we` = 0, `mem_req_addr` = 0, `mem_req_wdata` = 0, `vdata_out` = all lanes 0.
- **Reset mid-operation:** on the next edge, return to IDLE with all outputs at reset values. Any in-flight response that arrives afterwards is ignored.
- **Accept timing:** `start` sampled at edge T; `busy` and first `mem_req_valid` are high from cycle T+1.
- **Store latency:** with k enabled lanes and `mem_req_ready` tied high, requests occupy T+1..T+k and `done` pulses at T+k+1. Each stalled-ready cycle adds one cycle.
- **Load latency:** with k enabled lanes and response one cycle after acceptance, each lane costs 2 cycles and `done` pulses at T+2k+1.
- **Empty mask:** `done` at T+1 with no memory traffic.
- **Back-to-back:** a new `start` is accepted at the earliest in the cycle after `done` (IDLE). `vdata_out` is unchanged by stores.

## Test plan
- **Full store:** store, mask 1111, base 0x100, stride +1, data {A0,B1,C2,D3} (lanes 0..3), ready high. Required: 4 writes to 0x100..0x103 with matching data on cycles T+1..T+4, `done` at T+5, `busy` low at T+6.
- **Load with masked lane:** load, mask 1011, base 0x20, stride −2, responses 11, 22, 33 one cycle after each accept. Required: reads at 0x20, 0x1E, 0x1A only; `vdata_out` = {11, 22, 0, 33} for lanes 0..3; `done` at T+7.
- **Backpressure:** store, mask 0001, `mem_req_ready` low for 3 cycles. Required: `mem_req_valid`, addr and data held stable for 4 cycles; `done` the cycle after the ready handshake.
- **Empty mask and wrap:**
  - Mask 0000: `done` at T+1, no `mem_req_valid` activity.
  - Base 0xFFFFFFFFF, stride +1, mask 0011: addresses 0xFFFFFFFFF then 0x000000000.
- **Reset mid-load:** `rst` while in WAIT_RESP, then a stray `mem_resp_valid`. Required: IDLE with all outputs 0 the next cycle, and the stray response ignored.
- **Illegal events:**
  - `start` pulsed while busy: ignored.
  - `mem_resp_valid` asserted during REQ: ignored, result unchanged.
